inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 143 ++++++++++++++
 tb/tb_inst_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Buffers {pc, inst} pairs in a circular buffer and presents them in order to
// decode through a registered output stage. An empty queue lets a fetch go
// straight to the output register (zero-bubble path). A flush empties the
// queue and the output stage.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall[5:0]          pipeline stall vector; only bit 1 (decode hold) is used
//   flush               branch taken: discard queued and incoming instructions
//   if_valid/pc/inst    fetched instruction from IF
//   id_valid/pc/inst    registered instruction presented to ID
//   full                combinational, count == DEPTH (PC stall request)
//   count               occupied queue entries
//   overflow            sticky, a valid fetch was dropped
module inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_inst,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic          overflow_q, overflow_d;

  logic          hold;
  logic          q_empty, q_full;
  logic          pop, bypass, push, drop;
  logic [63:0]   head;

  // Only the decode-hold bit of the stall vector matters here.
  logic          unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign hold    = stall[1];
  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];

  // Queue handshake decode.
  always_comb begin
    pop    = !hold && !q_empty && !flush;
    bypass = !hold && q_empty && if_valid && !flush;
    push   = if_valid && !flush && !bypass && (!q_full || pop);
    drop   = if_valid && !flush && !bypass && !push;
  end

  // Next-state for pointers, count, output stage and overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    overflow_d = overflow_q;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop) overflow_d = 1'b1;

      // Output register updates only when decode is not holding.
      if (!hold) begin
        if (pop) begin
          id_valid_d = 1'b1;
          id_pc_d    = head[63:32];
          id_inst_d  = head[31:0];
        end else if (bypass) begin
          id_valid_d = 1'b1;
          id_pc_d    = if_pc;
          id_inst_d  = if_inst;
        end else begin
          id_valid_d = 1'b0;
          id_pc_d    = '0;
          id_inst_d  = '0;
        end
      end
    end
  end

  // Control and output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are unobservable while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {if_pc, if_inst};
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign full     = !rst && q_full;

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed vector table, async-reset sequence and a
// randomized phase checked against an ordered scoreboard of accepted fetches.
module tb_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    int          ecount;
    logic        efull;
    logic        eovf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst, input int ecount,
                         input logic efull, input logic eovf);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(ev));
    chk({tag, ".id_pc"},    id_pc,         epc);
    chk({tag, ".id_inst"},  id_inst,       einst);
    chk({tag, ".count"},    32'(count),    32'(ecount));
    chk({tag, ".full"},     32'(full),     32'(efull));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] inst);
    stall = st; flush = fl; if_valid = iv; if_pc = pc; if_inst = inst;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] st, input logic fl, input logic iv,
                     input logic [31:0] pc, input logic [31:0] inst,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input int ecount, input logic efull, input logic eovf);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst;
    v.ev = ev; v.epc = epc; v.einst = einst;
    v.ecount = ecount; v.efull = efull; v.eovf = eovf;
    vt.push_back(v);
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard state for the random phase.
  logic [63:0] sb[$];
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  logic        m_ovf;

  initial begin
    // Bypass into an empty queue.
    add(6'h00, 0, 1, 32'h0, 32'h34011100, 1, 32'h0, 32'h34011100, 0, 0, 0);
    // Fill under decode hold, then a fifth fetch is dropped.
    add(6'h02, 0, 1, 32'h0, 32'h11110000, 1, 32'h0, 32'h34011100, 1, 0, 0);
    add(6'h02, 0, 1, 32'h4, 32'h11110001, 1, 32'h0, 32'h34011100, 2, 0, 0);
    add(6'h02, 0, 1, 32'h8, 32'h11110002, 1, 32'h0, 32'h34011100, 3, 0, 0);
    add(6'h02, 0, 1, 32'hC, 32'h11110003, 1, 32'h0, 32'h34011100, 4, 1, 0);
    add(6'h02, 0, 1, 32'h10, 32'h11110004, 1, 32'h0, 32'h34011100, 4, 1, 1);
    // Drain in order, then a bubble.
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h11110000, 3, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h4, 32'h11110001, 2, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h8, 32'h11110002, 1, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'hC, 32'h11110003, 0, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 1);
    // Refill, then push+pop while full.
    add(6'h02, 0, 1, 32'h0, 32'h22220000, 0, 32'h0, 32'h0, 1, 0, 1);
    add(6'h02, 0, 1, 32'h4, 32'h22220001, 0, 32'h0, 32'h0, 2, 0, 1);
    add(6'h02, 0, 1, 32'h8, 32'h22220002, 0, 32'h0, 32'h0, 3, 0, 1);
    add(6'h02, 0, 1, 32'hC, 32'h22220003, 0, 32'h0, 32'h0, 4, 1, 1);
    add(6'h00, 0, 1, 32'h10, 32'h22220004, 1, 32'h0, 32'h22220000, 4, 1, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h4, 32'h22220001, 3, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h8, 32'h22220002, 2, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'hC, 32'h22220003, 1, 0, 1);
    add(6'h00, 0, 0, 32'h0, 32'h0, 1, 32'h10, 32'h22220004, 0, 0, 1);
    // Three entries queued under hold, then flush with a fetch present.
    add(6'h02, 0, 1, 32'h40, 32'h33330000, 1, 32'h10, 32'h22220004, 1, 0, 1);
    add(6'h02, 0, 1, 32'h44, 32'h33330001, 1, 32'h10, 32'h22220004, 2, 0, 1);
    add(6'h02, 0, 1, 32'h48, 32'h33330002, 1, 32'h10, 32'h22220004, 3, 0, 1);
    add(6'h02, 1, 1, 32'h4C, 32'h33330003, 0, 32'h0, 32'h0, 0, 0, 1);
    // Post-flush fetch takes the bypass path; unused stall bits ignored.
    add(6'h3D, 0, 1, 32'h50, 32'h44440000, 1, 32'h50, 32'h44440000, 0, 0, 1);

    do_reset();
    chk_all("reset", 0, 32'h0, 32'h0, 0, 0, 0);

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].fl, vt[i].iv, vt[i].pc, vt[i].inst);
      chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einst,
              vt[i].ecount, vt[i].efull, vt[i].eovf);
    end

    // Async reset between edges with two entries queued and id_valid set.
    drive(6'h02, 0, 1, 32'h60, 32'h55550000);
    drive(6'h02, 0, 1, 32'h64, 32'h55550001);
    chk_all("pre_rst", 1, 32'h50, 32'h44440000, 2, 0, 1);
    drive(6'h02, 0, 1, 32'h68, 32'h55550002);
    drive(6'h02, 0, 1, 32'h6C, 32'h55550003);
    chk_all("pre_rst_full", 1, 32'h50, 32'h44440000, 4, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 32'h0, 32'h0, 0, 0, 0);
    // Held in reset across an edge: fetch ignored, full stays low.
    if_valid = 1'b1; stall = 6'h02;
    @(posedge clk);
    #1;
    chk_all("in_rst", 0, 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    drive(6'h00, 0, 1, 32'h100, 32'h66660000);
    chk_all("post_rst_bypass", 1, 32'h100, 32'h66660000, 0, 0, 0);

    // Random phase against the scoreboard.
    do_reset();
    sb.delete();
    m_valid = 0; m_pc = '0; m_inst = '0; m_ovf = 0;
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  st;
      logic        fl, iv, e_pop, e_byp, e_push;
      logic [31:0] pc, inst;
      logic [63:0] e;
      st   = 6'($urandom);
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      pc   = 32'(n * 4 + 32'h1000);
      inst = $urandom;
      e_pop  = !st[1] && (sb.size() != 0) && !fl;
      e_byp  = !st[1] && (sb.size() == 0) && iv && !fl;
      e_push = iv && !fl && !e_byp && ((sb.size() < DEPTH) || e_pop);
      if (fl) begin
        sb.delete();
        m_valid = 0; m_pc = '0; m_inst = '0;
      end else begin
        if (!st[1]) begin
          if (e_pop) begin
            e = sb.pop_front();
            m_valid = 1; m_pc = e[63:32]; m_inst = e[31:0];
          end else if (e_byp) begin
            m_valid = 1; m_pc = pc; m_inst = inst;
          end else begin
            m_valid = 0; m_pc = '0; m_inst = '0;
          end
        end
        if (e_push) sb.push_back({pc, inst});
        if (iv && !e_byp && !e_push) m_ovf = 1;
      end
      drive(st, fl, iv, pc, inst);
      chk_all($sformatf("rnd%0d", n), m_valid, m_pc, m_inst, sb.size(),
              sb.size() == DEPTH, m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
